// File: rtl/divu_seq.sv
// Sequential unsigned restoring divider.
// One quotient bit per cycle, MSB first, with a single shared subtractor.
//
// state | meaning
// IDLE  | no result held, ready for a start
// BUSY  | iterating, one restoring step per cycle
// DONE  | result held on the outputs, ready for a start
module divu_seq #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         ready,
    output logic         valid,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);

    localparam int CW = $clog2(N) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    // dvd_q shifts dividend bits out of the top and quotient bits in at the
    // bottom, so it holds the quotient once the last step completes.
    logic [N-1:0]  dvd_q, dvd_d;
    logic [N-1:0]  dvs_q, dvs_d;
    logic [N:0]    rem_q, rem_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dbz_q, dbz_d;

    logic [N:0]    shifted;
    logic [N+1:0]  sum;
    logic          not_less;
    logic          unused_rem_msb;

    // The remainder entering a step is always below the divisor, so its
    // top bit is zero and only the low N bits need to be shifted up.
    assign unused_rem_msb = rem_q[N];

    // Shared subtractor: shifted + ~divisor + 1; carry-out means shifted >= divisor.
    always_comb begin
        shifted  = {rem_q[N-1:0], dvd_q[N-1]};
        sum      = {1'b0, shifted} + {1'b0, ~{1'b0, dvs_q}} + (N+2)'(1);
        not_less = sum[N+1];
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    dvs_d = divisor;
                    cnt_d = '0;
                    if (divisor == '0) begin
                        dvd_d   = '1;
                        rem_d   = {1'b0, dividend};
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        dvd_d   = dividend;
                        rem_d   = '0;
                        dbz_d   = 1'b0;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                rem_d = not_less ? sum[N:0] : shifted;
                dvd_d = {dvd_q[N-2:0], not_less};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            dbz_q   <= dbz_d;
        end
    end

    // Outputs are only driven from the held result in DONE.
    always_comb begin
        ready       = (state_q != BUSY);
        valid       = (state_q == DONE);
        quotient    = valid ? dvd_q : '0;
        remainder   = valid ? rem_q[N-1:0] : '0;
        div_by_zero = valid & dbz_q;
    end

endmodule
